wait_state_memory: RTL

Byte-addressed, big-endian data memory that acts as the responder side of the datapath's memory handshake (enable / opcode / address / data in, data out / MFC / MSET). Each access passes through a small state machine that inserts a configurable number of wait states, performs the SPARC load or store with size, sign and alignment handling, and then holds MFC until the requester drops its enable. The block replaces the zero-delay RAM model when the control unit is exercised against realistic memory latency.

---
 rtl/wait_state_memory.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/wait_state_memory.sv
// wait_state_memory
//
// Byte-addressed, big-endian data memory acting as the responder side of the
// datapath memory handshake. Every access walks through IDLE -> (WAIT) ->
// DONE, or IDLE -> ERR for misaligned or illegal requests. MFC and MSET are
// held until the requester drops RAM_enable.
//
// Parameters:
//   DEPTH      memory size in bytes (power of two)
//   ADDR_BITS  log2(DEPTH); only Address[ADDR_BITS-1:0] is decoded
//   LATENCY    wait states inserted before completion (0..15)
//
// Ports:
//   Clk         rising-edge clock
//   Clr         asynchronous active-high reset (memory contents are kept)
//   RAM_enable  request, held high until MFC is seen
//   RAM_OpCode  SPARC op3 of the access
//   Address     byte address
//   DataIn      store data, right-justified
//   DataOut     load result, right-justified and extended (registered)
//   MFC         memory function complete (registered)
//   MSET        memory exception, valid while MFC=1 (registered)
//
// Configuration macro:
//   WSMEM_WAIT_STATES_EN  when defined, LATENCY wait states are inserted;
//                         when undefined, the WAIT state and counter are
//                         removed and every legal access completes as if
//                         LATENCY were 0.

module wait_state_memory #(
    parameter int DEPTH     = 512,
    parameter int ADDR_BITS = 9,
    parameter int LATENCY   = 3
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        RAM_enable,
    input  logic [5:0]  RAM_OpCode,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MFC,
    output logic        MSET
);

    typedef logic [ADDR_BITS-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd1,
        ERR  = 2'd2
`ifdef WSMEM_WAIT_STATES_EN
        , WAIT = 2'd3
`endif
    } state_t;

    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDD  = 6'b000011;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;
    localparam logic [5:0] OP_STD  = 6'b000111;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;

    logic [7:0] mem [DEPTH];

    state_t      state_q, state_d;
    logic [5:0]  op_q, op_d;
    addr_t       addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] dout_q, dout_d;
    logic        mfc_q, mfc_d;
    logic        mset_q, mset_d;
`ifdef WSMEM_WAIT_STATES_EN
    localparam logic [3:0] CNT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
    logic [3:0]  cnt_q, cnt_d;
`endif

    logic [5:0]  cur_op;
    addr_t       cur_addr, a1, a2, a3;
    logic [31:0] cur_data;
    logic        legal, is_store, is_signed, misaligned, write_en;
    logic [1:0]  size;
    logic [31:0] load_val;

    logic unused_bits;
`ifdef WSMEM_WAIT_STATES_EN
    assign unused_bits = ^{Address[31:ADDR_BITS]};
`else
    assign unused_bits = ^{Address[31:ADDR_BITS], 4'(LATENCY)};
`endif

    // In IDLE the request is taken straight from the ports so that a
    // zero-wait access can complete at the latch edge; afterwards only the
    // latched copy is used, so later input changes are ignored.
    always_comb begin
        cur_op   = (state_q == IDLE) ? RAM_OpCode : op_q;
        cur_addr = (state_q == IDLE) ? Address[ADDR_BITS-1:0] : addr_q;
        cur_data = (state_q == IDLE) ? DataIn : data_q;
        a1 = cur_addr + addr_t'(1);
        a2 = cur_addr + addr_t'(2);
        a3 = cur_addr + addr_t'(3);

        legal     = 1'b1;
        is_store  = 1'b0;
        is_signed = 1'b0;
        size      = 2'd2;
        case (cur_op)
            OP_LD:   size = 2'd2;
            OP_LDUB: size = 2'd0;
            OP_LDUH: size = 2'd1;
            OP_LDD:  size = 2'd3;
            OP_ST:   begin size = 2'd2; is_store = 1'b1; end
            OP_STB:  begin size = 2'd0; is_store = 1'b1; end
            OP_STH:  begin size = 2'd1; is_store = 1'b1; end
            OP_STD:  begin size = 2'd3; is_store = 1'b1; end
            OP_LDSB: begin size = 2'd0; is_signed = 1'b1; end
            OP_LDSH: begin size = 2'd1; is_signed = 1'b1; end
            default: legal = 1'b0;
        endcase

        case (size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = cur_addr[0];
            2'd2:    misaligned = (cur_addr[1:0] != 2'b00);
            default: misaligned = (cur_addr[2:0] != 3'b000);
        endcase

        // Big-endian: the byte at the access address is the most significant.
        case (size)
            2'd0:    load_val = {{24{is_signed & mem[cur_addr][7]}}, mem[cur_addr]};
            2'd1:    load_val = {{16{is_signed & mem[cur_addr][7]}}, mem[cur_addr], mem[a1]};
            default: load_val = {mem[cur_addr], mem[a1], mem[a2], mem[a3]};
        endcase
    end

    // Next-state and output computation. The access itself (write or
    // DataOut update) happens on the edge that moves the FSM into DONE;
    // MFC/MSET are registered from the current state, so they rise one edge
    // after DONE/ERR is entered and fall on the edge that sees enable low.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        data_d   = data_q;
        dout_d   = dout_q;
        write_en = 1'b0;
`ifdef WSMEM_WAIT_STATES_EN
        cnt_d    = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (RAM_enable) begin
                    op_d   = RAM_OpCode;
                    addr_d = Address[ADDR_BITS-1:0];
                    data_d = DataIn;
                    if (!legal || misaligned) begin
                        state_d = ERR;
                    end else begin
`ifdef WSMEM_WAIT_STATES_EN
                        if (LATENCY == 0) begin
                            state_d = DONE;
                        end else begin
                            cnt_d   = CNT_LOAD;
                            state_d = WAIT;
                        end
`else
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef WSMEM_WAIT_STATES_EN
            WAIT: begin
                if (!RAM_enable) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            DONE: if (!RAM_enable) state_d = IDLE;
            ERR:  if (!RAM_enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == DONE && state_q != DONE) begin
            if (is_store) begin
                write_en = !Clr;
            end else begin
                dout_d = load_val;
            end
        end

        mfc_d  = RAM_enable && (state_q == DONE || state_q == ERR);
        mset_d = RAM_enable && (state_q == ERR);
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q <= IDLE;
            op_q    <= 6'd0;
            addr_q  <= '0;
            data_q  <= 32'd0;
            dout_q  <= 32'd0;
            mfc_q   <= 1'b0;
            mset_q  <= 1'b0;
`ifdef WSMEM_WAIT_STATES_EN
            cnt_q   <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            dout_q  <= dout_d;
            mfc_q   <= mfc_d;
            mset_q  <= mset_d;
`ifdef WSMEM_WAIT_STATES_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Storage is never reset; stores write only the bytes their size covers.
    always_ff @(posedge Clk) begin
        if (write_en) begin
            case (size)
                2'd0: mem[cur_addr] <= cur_data[7:0];
                2'd1: begin
                    mem[cur_addr] <= cur_data[15:8];
                    mem[a1]       <= cur_data[7:0];
                end
                default: begin
                    mem[cur_addr] <= cur_data[31:24];
                    mem[a1]       <= cur_data[23:16];
                    mem[a2]       <= cur_data[15:8];
                    mem[a3]       <= cur_data[7:0];
                end
            endcase
        end
    end

    assign DataOut = dout_q;
    assign MFC     = mfc_q;
    assign MSET    = mset_q;

endmodule
